// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : issue_pkg
// Description : Shared opcode constants, load latency and opcode-class decode
//               helpers for the dual-issue scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package issue_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t NOP = 4'h0;
    localparam opcode_t LD  = 4'hA;
    localparam opcode_t ST  = 4'hB;
    localparam opcode_t BR  = 4'hD;

    // Cycles from load issue to result; dependents wait LAT_LOAD-1 cycles.
    localparam int LAT_LOAD = 3;

    function automatic logic is_mem(input opcode_t op);
        return (op == LD) || (op == ST);
    endfunction

    function automatic logic is_br(input opcode_t op);
        return (op == BR);
    endfunction

    function automatic logic writes_rd(input opcode_t op);
        return !((op == NOP) || (op == ST) || (op == BR));
    endfunction

    function automatic logic reads_rs1(input opcode_t op);
        return (op != NOP);
    endfunction

    // Stores and branches always consume rs2; only ALU ops honour imm_flag.
    function automatic logic reads_rs2(input opcode_t op, input logic imm);
        logic r;
        case (op)
            NOP, LD: r = 1'b0;
            ST, BR:  r = 1'b1;
            default: r = !imm;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler_scoreboard
// Description : Per-register pending-write counters. A register is busy while
//               its counter is nonzero. Busy lookups use the registered count.
// Ports       : clk, reset (async active-low)
//               set_en[1:0], set_idx[1:0] - load issue, loads LAT_LOAD-1
//               look_idx[5:0]             - register indices to query
//               busy[5:0]                 - busy flag per query
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2,
    parameter int LAT_LOAD = 3,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            set_en,
    input  logic [1:0][IDX_W-1:0] set_idx,
    input  logic [5:0][IDX_W-1:0] look_idx,
    output logic [5:0]            busy
);

    localparam logic [CNT_W-1:0] C_LOAD_CNT = CNT_W'(LAT_LOAD - 1);

    logic [CNT_W-1:0] r_cnt [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if ((set_en[0] && (set_idx[0] == IDX_W'(r))) ||
                    (set_en[1] && (set_idx[1] == IDX_W'(r)))) begin
                    r_cnt[r] <= C_LOAD_CNT;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - 1'b1;
                end
            end
        end
    end

    generate
        for (genvar i = 0; i < 6; i++) begin : g_lookup
            assign busy[i] = (r_cnt[look_idx[i]] != '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : issue_scheduler
// Description : Dual-issue in-order scheduler. Checks scoreboard and intra-pair
//               hazards, decides issue per slot, drives stall and flush.
// Ports       : clk, reset (async active-low), is_branch_taken
//               slot n: validn, opcoden, rdn, rs1_n, rs2_n, imm_flagn
//               issue0, issue1, stall, flush
// Revision    : 1.0 - initial release
// ============================================================================
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2,
    localparam int IDX_W   = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             is_branch_taken,
    input  logic             valid0,
    input  logic [3:0]       opcode0,
    input  logic [IDX_W-1:0] rd0,
    input  logic [IDX_W-1:0] rs1_0,
    input  logic [IDX_W-1:0] rs2_0,
    input  logic             imm_flag0,
    input  logic             valid1,
    input  logic [3:0]       opcode1,
    input  logic [IDX_W-1:0] rd1,
    input  logic [IDX_W-1:0] rs1_1,
    input  logic [IDX_W-1:0] rs2_1,
    input  logic             imm_flag1,
    output logic             issue0,
    output logic             issue1,
    output logic             stall,
    output logic             flush
);

    logic       r_done0;
    logic [5:0] w_busy;
    logic       w_hz0;
    logic       w_hz1;
    logic       w_pair_ok;
    logic       w_wr0;
    logic       w_wr1;

    issue_scheduler_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .LAT_LOAD (LAT_LOAD)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   ({issue1 && (opcode1 == LD), issue0 && (opcode0 == LD)}),
        .set_idx  ({rd1, rd0}),
        .look_idx ({rd1, rs2_1, rs1_1, rd0, rs2_0, rs1_0}),
        .busy     (w_busy)
    );

    assign w_wr0 = writes_rd(opcode0);
    assign w_wr1 = writes_rd(opcode1);

    // Scoreboard hazards (RAW on sources, WAW on destination).
    assign w_hz0 = (reads_rs1(opcode0) && w_busy[0]) ||
                   (reads_rs2(opcode0, imm_flag0) && w_busy[1]) ||
                   (w_wr0 && w_busy[2]);
    assign w_hz1 = (reads_rs1(opcode1) && w_busy[3]) ||
                   (reads_rs2(opcode1, imm_flag1) && w_busy[4]) ||
                   (w_wr1 && w_busy[5]);

    // Same-cycle pairing restrictions; only relevant when slot 0 issues now.
    assign w_pair_ok = !issue0 ||
        !((w_wr0 && reads_rs1(opcode1) && (rs1_1 == rd0)) ||
          (w_wr0 && reads_rs2(opcode1, imm_flag1) && (rs2_1 == rd0)) ||
          (w_wr0 && w_wr1 && (rd1 == rd0)) ||
          (is_mem(opcode0) && is_mem(opcode1)) ||
          is_br(opcode1) || is_br(opcode0));

    // Outputs are gated by reset so they read 0 the instant reset asserts.
    assign flush  = reset && is_branch_taken;
    assign issue0 = reset && valid0 && !r_done0 && !is_branch_taken && !w_hz0;
    assign issue1 = reset && valid1 && !is_branch_taken && (issue0 || r_done0) &&
                    !w_hz1 && w_pair_ok;
    assign stall  = reset && !is_branch_taken &&
                    ((valid0 && !r_done0 && !issue0) || (valid1 && !issue1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done0 <= 1'b0;
        end else if (flush || issue1) begin
            r_done0 <= 1'b0;
        end else if (issue0 && valid1) begin
            r_done0 <= 1'b1;
        end
    end

endmodule
`default_nettype wire
